hex_parser: RTL
===============

# hex_parser

Sequential ASCII-hex-to-binary parser: consumes one character per accepted handshake, accumulates hex digits most-significant first, and emits the binary value once a terminator character arrives. It is the receive-side counterpart of the nibble-to-hex-char conversion used on the serial/text output path. It sits behind a UART receiver or similar character source and feeds a command/register-write decoder.

## Interface
- NUM_DIGITS, 4: maximum number of hex digits per value.
- CHAR_SIZE, 8: width of one input character.
- DIGIT_SIZE, 4: bits per hex digit.
- in_clk  in  1  system clock; all logic on rising edge.
- in_rst_n  in  1  reset, synchronous, active-low.
- in_char  in  CHAR_SIZE  ASCII character.
- in_char_valid  in  1  in_char is valid.
- out_char_ready  out  1  block accepts a character this cycle.
- out_value  out  DIGIT_SIZE*NUM_DIGITS  parsed value, right-aligned.
- out_num_digits  out  $clog2(NUM_DIGITS+1)  digits in out_value, saturating at NUM_DIGITS.
- out_error  out  1  value is invalid (overflow or bad char); qualified by out_value_valid.
- out_value_valid  out  1  out_value/out_num_digits/out_error are valid.
- in_value_ready  in  1  consumer accepts the value.

## Operation
- A character is accepted on a rising edge where in_char_valid && out_char_ready.
- Digit set: '0'-'9' (0x30-0x39) -> 0-9, 'a'-'f' (0x61-0x66) -> 10-15. Terminators: '\n' (0x0a), '\r' (0x0d), ' ' (0x20). All other characters are invalid.
- States:
  - S_ACCUM: out_char_ready=1. Digit: acc <= {acc, digit} (left shift by DIGIT_SIZE, truncated to DIGIT_SIZE*NUM_DIGITS); count++ saturating; if count was already NUM_DIGITS, set overflow flag. Terminator with count=0: ignored, stay. Terminator with count>0: -> S_OUTPUT. Invalid char: -> S_SKIP.
  - S_SKIP: out_char_ready=1. Discard digits and invalid chars. Terminator -> S_OUTPUT with acc=0, count=0, error=1.
  - S_OUTPUT: out_char_ready=0, out_value_valid=1, out_error = overflow or skip. On in_value_ready: clear acc, count and flags; -> S_ACCUM.
- Overflow keeps the lowest NUM_DIGITS digits (e.g. last four).
- Empty terminator runs ("\n\r", "  ") produce no output.

## Timing
- Reset (in_rst_n low on an edge): state S_ACCUM, out_value=0, out_num_digits=0, out_error=0, out_value_valid=0; out_char_ready=1 in the first cycle after reset.
- Reset mid-string discards partial acc; reset in S_OUTPUT drops the pending value.
- Latency: out_value_valid rises the cycle after the terminator's accepting edge.
- out_value, out_num_digits, out_error are registered, held stable while out_value_valid=1 and in_value_ready=0.
- Value handshake completes on the edge where out_value_valid && in_value_ready; out_char_ready is 1 in the next cycle (minimum one dead cycle between strings).
- in_value_ready is ignored outside S_OUTPUT; in_char_valid is ignored in S_OUTPUT.
- Throughput: one character per cycle in S_ACCUM/S_SKIP.

## Configuration
- HEX_PARSER_UPPERCASE_EN defined: 'A'-'F' (0x41-0x46) are also digits 10-15.
- Not defined: uppercase letters are invalid characters (-> S_SKIP, error).

## Test plan
- "1a2f\n" back-to-back, in_value_ready=1 -> out_value=0x1a2f, out_num_digits=4, out_error=0, out_value_valid high exactly 1 cycle, one cycle after '\n' accepted.
- "7 " then "\r\n" -> single output 0x0007, num_digits=1, error=0; the empty terminators produce no output.
- "12345\n" -> out_value=0x2345, num_digits=4, error=1.
- "1g2\n" -> out_value=0x0000, num_digits=0, error=1; next "ab\n" -> 0x00ab, error=0.
- Back-pressure: "c0de\n" with in_value_ready low 3 cycles -> value 0xc0de held stable, out_char_ready=0 throughout; handshake on 4th cycle, ready=1 next cycle.
- Reset mid-operation: "12", reset pulse, then "3\n" -> 0x0003, num_digits=1; "BEEF\n" -> 0xbeef with HEX_PARSER_UPPERCASE_EN, else error=1, value 0.

Source files
------------

// File: rtl/hex_parser.sv
// ASCII-hex to binary parser: accumulates hex digits MSB-first and emits the value on a terminator.
// Optional macro HEX_PARSER_UPPERCASE_EN also accepts 'A'-'F' as digits.
module hex_parser #(
    parameter int NUM_DIGITS = 4,
    parameter int CHAR_SIZE  = 8,
    parameter int DIGIT_SIZE = 4
) (
    input  logic                                 in_clk,
    input  logic                                 in_rst_n,
    input  logic [CHAR_SIZE-1:0]                 in_char,
    input  logic                                 in_char_valid,
    output logic                                 out_char_ready,
    output logic [DIGIT_SIZE*NUM_DIGITS-1:0]     out_value,
    output logic [$clog2(NUM_DIGITS+1)-1:0]      out_num_digits,
    output logic                                 out_error,
    output logic                                 out_value_valid,
    input  logic                                 in_value_ready
);

    localparam int VW = DIGIT_SIZE * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);

    typedef enum logic [1:0] {
        S_ACCUM  = 2'd0,
        S_SKIP   = 2'd1,
        S_OUTPUT = 2'd2
    } state_t;

    function automatic logic is_dec(input logic [CHAR_SIZE-1:0] c);
        return (c >= CHAR_SIZE'(8'h30)) && (c <= CHAR_SIZE'(8'h39));
    endfunction

    function automatic logic is_alpha(input logic [CHAR_SIZE-1:0] c);
`ifdef HEX_PARSER_UPPERCASE_EN
        return ((c >= CHAR_SIZE'(8'h61)) && (c <= CHAR_SIZE'(8'h66))) ||
               ((c >= CHAR_SIZE'(8'h41)) && (c <= CHAR_SIZE'(8'h46)));
`else
        return (c >= CHAR_SIZE'(8'h61)) && (c <= CHAR_SIZE'(8'h66));
`endif
    endfunction

    function automatic logic is_term(input logic [CHAR_SIZE-1:0] c);
        return (c == CHAR_SIZE'(8'h0a)) || (c == CHAR_SIZE'(8'h0d)) || (c == CHAR_SIZE'(8'h20));
    endfunction

    // Low nibble of '0'-'9' is the value; 'a'/'A' both have low nibble 1, so letters add 9.
    function automatic logic [DIGIT_SIZE-1:0] digit_val(input logic [CHAR_SIZE-1:0] c);
        return is_dec(c) ? DIGIT_SIZE'(c[3:0]) : DIGIT_SIZE'(c[3:0] + 4'd9);
    endfunction

    state_t                  state_q;
    logic [VW-1:0]           acc_q;
    logic [CW-1:0]           count_q;
    logic                    ovf_q;
    logic                    err_q;
    logic                    valid_q;
    logic                    ready_q;

    logic                    char_fire_s;
    logic                    is_digit_s;
    logic                    is_term_s;
    logic [DIGIT_SIZE-1:0]   digit_s;
    logic                    count_full_s;
    logic [VW-1:0]           acc_d;
    logic [CW-1:0]           count_d;
    logic                    ovf_d;

    assign char_fire_s  = in_char_valid && ready_q;
    assign is_digit_s   = is_dec(in_char) || is_alpha(in_char);
    assign is_term_s    = is_term(in_char);
    assign digit_s      = digit_val(in_char);
    assign count_full_s = (count_q == CW'(NUM_DIGITS));
    assign acc_d        = {acc_q[VW-DIGIT_SIZE-1:0], digit_s};
    assign count_d      = count_full_s ? count_q : count_q + CW'(1);
    assign ovf_d        = ovf_q | count_full_s;

    assign out_char_ready  = ready_q;
    assign out_value       = acc_q;
    assign out_num_digits  = count_q;
    assign out_error       = err_q;
    assign out_value_valid = valid_q;

    // Parser state machine; all outputs come straight from these registers.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state_q <= S_ACCUM;
            acc_q   <= {VW{1'b0}};
            count_q <= {CW{1'b0}};
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                S_ACCUM: begin
                    if (char_fire_s) begin
                        if (is_digit_s) begin
                            acc_q   <= acc_d;
                            count_q <= count_d;
                            ovf_q   <= ovf_d;
                        end else if (is_term_s) begin
                            // Empty terminator runs are swallowed without producing a value.
                            if (count_q != {CW{1'b0}}) begin
                                state_q <= S_OUTPUT;
                                err_q   <= ovf_q;
                                valid_q <= 1'b1;
                                ready_q <= 1'b0;
                            end
                        end else begin
                            state_q <= S_SKIP;
                        end
                    end
                end
                S_SKIP: begin
                    if (char_fire_s && is_term_s) begin
                        state_q <= S_OUTPUT;
                        acc_q   <= {VW{1'b0}};
                        count_q <= {CW{1'b0}};
                        err_q   <= 1'b1;
                        valid_q <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                S_OUTPUT: begin
                    if (in_value_ready) begin
                        state_q <= S_ACCUM;
                        acc_q   <= {VW{1'b0}};
                        count_q <= {CW{1'b0}};
                        ovf_q   <= 1'b0;
                        err_q   <= 1'b0;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_ACCUM;
                    acc_q   <= {VW{1'b0}};
                    count_q <= {CW{1'b0}};
                    ovf_q   <= 1'b0;
                    err_q   <= 1'b0;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule
